a23_mini_sys_gpio: RTL and testbench

Wishbone-classic slave peripheral inside a23_mini_sys. It is the responder end of the board switch/LED interface: it receives the sw1..sw4 pins driven by the testbench, and it drives the led0..led3 pins that the testbench observes.
- Switch path: synchronise, debounce, edge-detect into a maskable interrupt.
- LED path: drive LEDs from a CPU-writable register.
- Serves the a23 core's data bus; the interrupt goes to the core irq input.

---
 rtl/a23_mini_sys_gpio_pkg.sv | 16 +
 rtl/a23_mini_sys_gpio_debounce.sv | 56 +++++
 rtl/a23_mini_sys_gpio.sv | 133 +++++++++++++
 tb/tb_a23_mini_sys_gpio.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/a23_mini_sys_gpio_pkg.sv
// Shared constants and helpers for the a23_mini_sys GPIO peripheral.
package a23_mini_sys_gpio_pkg;

    localparam logic [1:0] GPIO_LED_OUT  = 2'd0;
    localparam logic [1:0] GPIO_SW_IN    = 2'd1;
    localparam logic [1:0] GPIO_IRQ_STAT = 2'd2;
    localparam logic [1:0] GPIO_IRQ_EN   = 2'd3;

    localparam int GPIO_DEBOUNCE_DEFAULT = 16;

    // Expand Wishbone byte selects into a per-bit write mask.
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/a23_mini_sys_gpio_debounce.sv
// Single-bit switch conditioner: two-flop synchroniser, debounce counter,
// debounced state and a one-cycle edge pulse coincident with the state flip.
module gpio_debounce
    import a23_mini_sys_gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_pin,
    output logic o_state,
    output logic o_edge
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_flip;

    assign w_diff = r_sync2 ^ r_state;
    assign w_flip = w_diff & (r_cnt == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    // Any sample that agrees with the accepted level restarts the stability count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= 1'b0;
            r_cnt   <= '0;
        end else if (!w_diff) begin
            r_cnt   <= '0;
        end else if (w_flip) begin
            r_state <= ~r_state;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_state = r_state;
    assign o_edge  = w_flip;

endmodule

// File: rtl/a23_mini_sys_gpio.sv
// Wishbone-classic GPIO slave: LED output register, debounced switch inputs,
// W1C edge status with enable mask and a registered level interrupt.
module a23_mini_sys_gpio
    import a23_mini_sys_gpio_pkg::*;
#(
    parameter int N_GPIO          = 4,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       i_wb_adr,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_dat,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic [31:0]       o_wb_dat,
    output logic              o_wb_ack,
    input  logic [N_GPIO-1:0] sw_i,
    output logic [N_GPIO-1:0] led_o,
    output logic              o_irq
);

    logic [N_GPIO-1:0] r_led;
    logic [N_GPIO-1:0] r_irq_stat;
    logic [N_GPIO-1:0] r_irq_en;
    logic              r_ack;
    logic [31:0]       r_rdat;
    logic              r_irq;

    logic              w_req;
    logic [1:0]        w_idx;
    logic [31:0]       w_mask32;
    logic [N_GPIO-1:0] w_wmask;
    logic [N_GPIO-1:0] w_wdat;
    logic              w_wr_led;
    logic              w_wr_stat;
    logic              w_wr_en;
    logic [N_GPIO-1:0] w_clr;
    logic [N_GPIO-1:0] w_sw_state;
    logic [N_GPIO-1:0] w_edge;
    logic [31:0]       w_rdata;
    logic              w_unused_bits;

    genvar gi;
    generate
        for (gi = 0; gi < N_GPIO; gi++) begin : g_db
            gpio_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_db (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .i_pin   (sw_i[gi]),
                .o_state (w_sw_state[gi]),
                .o_edge  (w_edge[gi])
            );
        end
    endgenerate

    // The ack term keeps a held strobe from being accepted twice.
    assign w_req     = i_wb_cyc & i_wb_stb & ~r_ack;
    assign w_idx     = i_wb_adr[3:2];
    assign w_mask32  = sel_to_mask(i_wb_sel);
    assign w_wmask   = w_mask32[N_GPIO-1:0];
    assign w_wdat    = i_wb_dat[N_GPIO-1:0] & w_wmask;
    assign w_wr_led  = w_req & i_wb_we & (w_idx == GPIO_LED_OUT);
    assign w_wr_stat = w_req & i_wb_we & (w_idx == GPIO_IRQ_STAT);
    assign w_wr_en   = w_req & i_wb_we & (w_idx == GPIO_IRQ_EN);

    assign w_unused_bits = ^{i_wb_adr[31:4], i_wb_adr[1:0], i_wb_dat, w_mask32};

    always_comb begin
        if (w_wr_stat) begin
            w_clr = w_wdat;
        end else begin
            w_clr = '0;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            GPIO_LED_OUT:  w_rdata[N_GPIO-1:0] = r_led;
            GPIO_SW_IN:    w_rdata[N_GPIO-1:0] = w_sw_state;
            GPIO_IRQ_STAT: w_rdata[N_GPIO-1:0] = r_irq_stat;
            GPIO_IRQ_EN:   w_rdata[N_GPIO-1:0] = r_irq_en;
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_led    <= '0;
            r_irq_en <= '0;
        end else begin
            if (w_wr_led) begin
                r_led <= (r_led & ~w_wmask) | w_wdat;
            end
            if (w_wr_en) begin
                r_irq_en <= (r_irq_en & ~w_wmask) | w_wdat;
            end
        end
    end

    // OR-ing the edge after the clear makes a coincident set win.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq_stat <= '0;
        end else begin
            r_irq_stat <= (r_irq_stat & ~w_clr) | w_edge;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack  <= 1'b0;
            r_rdat <= 32'h0000_0000;
            r_irq  <= 1'b0;
        end else begin
            r_ack  <= w_req;
            r_rdat <= w_req ? w_rdata : 32'h0000_0000;
            r_irq  <= |(r_irq_stat & r_irq_en);
        end
    end

    assign led_o    = r_led;
    assign o_wb_ack = r_ack;
    assign o_wb_dat = r_rdat;
    assign o_irq    = r_irq;

endmodule

// File: tb/tb_a23_mini_sys_gpio.sv
// Self-checking bench for a23_mini_sys_gpio: register vector table plus
// timed sequences for debounce, interrupt and reset behaviour.
module tb_a23_mini_sys_gpio;

    localparam int D = 16;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdat;
    logic        cyc;
    logic        stb;
    logic [31:0] rdat;
    logic        ack;
    logic [3:0]  sw;
    logic [3:0]  led;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [32:0] sb[$];
    logic [32:0] ent;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp_rd;
        logic [3:0]  exp_led;
    } vec_t;

    vec_t tv[16];

    a23_mini_sys_gpio #(.N_GPIO(4), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .i_wb_adr (adr),
        .i_wb_sel (sel),
        .i_wb_we  (we),
        .i_wb_dat (wdat),
        .i_wb_cyc (cyc),
        .i_wb_stb (stb),
        .o_wb_dat (rdat),
        .o_wb_ack (ack),
        .sw_i     (sw),
        .led_o    (led),
        .o_irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every ack must match a queued transfer; reads compare data.
    always @(negedge clk) begin
        if (!rst && ack) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 32'd1, 32'd0);
            end else begin
                ent = sb.pop_front();
                if (ent[32]) check("rd_data", rdat, ent[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; the request edge is the next posedge.
    task automatic wb(input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic [31:0] exp);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        sb.push_back({~w, exp});
        step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("ack_rise", {31'd0, ack}, 32'd1);
        step();
        check("ack_fall", {31'd0, ack}, 32'd0);
        check("dat_idle", rdat, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{1'b0, 32'h0,  4'hF, 32'h0,         32'h0, 4'h0};
        tv[1]  = '{1'b0, 32'h4,  4'hF, 32'h0,         32'h0, 4'h0};
        tv[2]  = '{1'b0, 32'h8,  4'hF, 32'h0,         32'h0, 4'h0};
        tv[3]  = '{1'b0, 32'hC,  4'hF, 32'h0,         32'h0, 4'h0};
        tv[4]  = '{1'b1, 32'h0,  4'hF, 32'h0000_000A, 32'h0, 4'hA};
        tv[5]  = '{1'b1, 32'h0,  4'h0, 32'h0000_0005, 32'h0, 4'hA};
        tv[6]  = '{1'b0, 32'h0,  4'hF, 32'h0,         32'hA, 4'hA};
        tv[7]  = '{1'b1, 32'h4,  4'hF, 32'h0000_000F, 32'h0, 4'hA};
        tv[8]  = '{1'b0, 32'h4,  4'hF, 32'h0,         32'h0, 4'hA};
        tv[9]  = '{1'b1, 32'h0,  4'h2, 32'h0000_0F05, 32'h0, 4'hA};
        tv[10] = '{1'b1, 32'hC,  4'h1, 32'hFFFF_FFF3, 32'h0, 4'hA};
        tv[11] = '{1'b0, 32'hC,  4'hF, 32'h0,         32'h3, 4'hA};
        tv[12] = '{1'b1, 32'hC,  4'hE, 32'h0,         32'h0, 4'hA};
        tv[13] = '{1'b0, 32'hC,  4'hF, 32'h0,         32'h3, 4'hA};
        tv[14] = '{1'b1, 32'hC,  4'hF, 32'h0,         32'h0, 4'hA};
        tv[15] = '{1'b0, 32'h10, 4'hF, 32'h0,         32'hA, 4'hA};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 32'h0; sel = 4'h0; wdat = 32'h0; sw = 4'h0;
        #3;
        check("rst_led", {28'd0, led}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_ack", {31'd0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Register map, byte lanes, RO and alias behaviour
        for (int i = 0; i < 16; i++) begin
            wb(tv[i].we, tv[i].adr, tv[i].sel, tv[i].dat, tv[i].exp_rd);
            check($sformatf("vec%0d_led", i), {28'd0, led}, {28'd0, tv[i].exp_led});
        end

        // Glitches of D-2 and D-1 samples are rejected
        for (int g = D - 2; g <= D - 1; g++) begin
            sw[1] = 1'b1;
            repeat (g) step();
            sw[1] = 1'b0;
            repeat (25) step();
            wb(1'b0, 32'h4, 4'hF, 32'h0, 32'h0);
            wb(1'b0, 32'h8, 4'hF, 32'h0, 32'h0);
        end

        // Rising: state still old at request edge 18, new afterwards
        sw[1] = 1'b1;
        repeat (D + 1) step();
        wb(1'b0, 32'h4, 4'hF, 32'h0, 32'h0);
        wb(1'b0, 32'h4, 4'hF, 32'h0, 32'h2);
        wb(1'b0, 32'h8, 4'hF, 32'h0, 32'h2);
        repeat (10) step();

        // Falling: already flipped when read at request edge 19
        sw[1] = 1'b0;
        repeat (D + 2) step();
        wb(1'b0, 32'h4, 4'hF, 32'h0, 32'h0);
        wb(1'b0, 32'h8, 4'hF, 32'h0, 32'h2);

        // Interrupt timing, W1C and enable masking
        wb(1'b1, 32'h8, 4'hF, 32'h2, 32'h0);
        wb(1'b0, 32'h8, 4'hF, 32'h0, 32'h0);
        wb(1'b1, 32'hC, 4'hF, 32'h2, 32'h0);
        check("irq_idle", {31'd0, irq}, 32'd0);
        sw[1] = 1'b1;
        repeat (D + 1) step();
        check("irq_pre_stat", {31'd0, irq}, 32'd0);
        step();
        check("irq_stat_cycle", {31'd0, irq}, 32'd0);
        step();
        check("irq_after_stat", {31'd0, irq}, 32'd1);
        wb(1'b1, 32'h8, 4'hF, 32'h2, 32'h0);
        check("irq_w1c", {31'd0, irq}, 32'd0);
        sw[1] = 1'b0;
        repeat (25) step();
        check("irq_fall_edge", {31'd0, irq}, 32'd1);
        wb(1'b1, 32'hC, 4'hF, 32'h0, 32'h0);
        check("irq_en_off", {31'd0, irq}, 32'd0);
        wb(1'b0, 32'h8, 4'hF, 32'h0, 32'h2);

        // W1C colliding with the debounced edge of bit 0: set wins
        sw[0] = 1'b1;
        repeat (D + 1) step();
        wb(1'b1, 32'h8, 4'h1, 32'h1, 32'h0);
        wb(1'b0, 32'h8, 4'hF, 32'h0, 32'h3);
        wb(1'b0, 32'h4, 4'hF, 32'h0, 32'h1);
        wb(1'b1, 32'h8, 4'hF, 32'h0, 32'h0);
        wb(1'b0, 32'h8, 4'hF, 32'h0, 32'h3);
        wb(1'b1, 32'h8, 4'hF, 32'h3, 32'h0);
        wb(1'b0, 32'h8, 4'hF, 32'h0, 32'h0);

        // Strobe held: one ack per two cycles
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
        sb.push_back({1'b1, 32'hA});
        sb.push_back({1'b1, 32'hA});
        step();
        check("held_ack0", {31'd0, ack}, 32'd1);
        step();
        check("held_ack1", {31'd0, ack}, 32'd0);
        step();
        check("held_ack2", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0;
        step();
        check("held_ack3", {31'd0, ack}, 32'd0);

        // Reset with an ack pending, switches held high through reset
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4; sel = 4'hF;
        step();
        rst = 1'b1;
        #1;
        check("rst_drop_ack", {31'd0, ack}, 32'd0);
        check("rst_drop_dat", rdat, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        sw = 4'hF;
        check("rst2_led", {28'd0, led}, 32'h0);
        check("rst2_irq", {31'd0, irq}, 32'h0);
        repeat (3) step();
        rst = 1'b0;
        repeat (D + 1) step();
        wb(1'b0, 32'h4, 4'hF, 32'h0, 32'h0);
        wb(1'b0, 32'h4, 4'hF, 32'h0, 32'hF);
        wb(1'b0, 32'h8, 4'hF, 32'h0, 32'hF);
        wb(1'b0, 32'h0, 4'hF, 32'h0, 32'h0);
        wb(1'b0, 32'hC, 4'hF, 32'h0, 32'h0);

        repeat (2) step();
        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
